// File: rtl/param_lp_control_unit.sv
// Opcode decoder with a RUN/SLEEP/WAKE low-power controller.
// Decoded controls are registered one cycle after acceptance and hold between acceptances.
module param_lp_control_unit #(
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [OPC_W-1:0] opcode,
  output logic             in_ready,
  output logic             out_valid,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             branch,
  output logic             jump,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic             clk_en,
  output logic             sleep
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                 alu_src: 1'b0, branch: 1'b0, jump: 1'b0,
                                 alu_op: 3'b111, illegal: 1'b0};

  function automatic ctrl_t decode(input logic [OPC_W-1:0] opc);
    ctrl_t      c;
    logic [7:0] v;
    v = 8'(opc);
    c = CTRL_RST;
    case (v)
      8'd0: c.alu_op = 3'b111;
      8'd1: begin c.reg_write = 1'b1; c.alu_op = 3'b000; end
      8'd2: begin c.reg_write = 1'b1; c.alu_op = 3'b001; end
      8'd3: begin c.reg_write = 1'b1; c.alu_op = 3'b010; end
      8'd4: begin c.reg_write = 1'b1; c.alu_op = 3'b011; end
      8'd5: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b000; end
      8'd6: begin
        c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b000;
      end
      8'd7: begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b000; end
      8'd8: begin c.branch = 1'b1; c.alu_op = 3'b001; end
      8'd9: begin c.jump = 1'b1; c.alu_op = 3'b111; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [WAKE_W-1:0]   wake_q, wake_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                clk_en_q, clk_en_d;
  logic                sleep_q, sleep_d;
  logic                accept_s;

  // Next-state, counter and decode logic.
  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    wake_d   = wake_q;
    accept_s = in_valid && in_ready_q;
    out_valid_d = accept_s;
    if (accept_s) begin
      ctrl_d = decode(opcode);
    end else begin
      ctrl_d = ctrl_q;
    end
    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          idle_d = {IDLE_W{1'b0}};
        end else if (idle_q == IDLE_LAST) begin
          idle_d  = {IDLE_W{1'b0}};
          state_d = ST_SLEEP;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_SLEEP: begin
        if (in_valid) begin
          state_d = ST_WAKE;
          wake_d  = {WAKE_W{1'b0}};
        end else begin
          state_d = ST_SLEEP;
        end
      end
      ST_WAKE: begin
        if (wake_q == WAKE_LAST) begin
          wake_d  = {WAKE_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          wake_d = wake_q + WAKE_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        idle_d  = {IDLE_W{1'b0}};
        wake_d  = {WAKE_W{1'b0}};
      end
    endcase
    // Power outputs come from the next registered state so they leave a flop directly.
    in_ready_d = (state_d == ST_RUN);
    clk_en_d   = (state_d != ST_SLEEP);
    sleep_d    = (state_d == ST_SLEEP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      idle_q      <= {IDLE_W{1'b0}};
      wake_q      <= {WAKE_W{1'b0}};
      ctrl_q      <= CTRL_RST;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      clk_en_q    <= 1'b1;
      sleep_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      wake_q      <= wake_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      clk_en_q    <= clk_en_d;
      sleep_q     <= sleep_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign reg_write = ctrl_q.reg_write;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign alu_src   = ctrl_q.alu_src;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign alu_op    = ctrl_q.alu_op;
  assign illegal   = ctrl_q.illegal;
  assign clk_en    = clk_en_q;
  assign sleep     = sleep_q;

endmodule
